// File: rtl/keychain_frame_assembler.sv
// Frames a UART byte stream (SOF, mode, key, msg, XOR checksum) into wide key/message buses.
// Frame valid rises one clock after the checksum byte and holds until ready; bytes arriving while it is held are dropped and flagged as overrun.
module keychain_frame_assembler #(
  parameter int          KEY_BYTES      = 2,
  parameter int          MSG_BYTES      = 1,
  parameter logic [7:0]  SOF_BYTE       = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 100_000
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   byte_valid_in,
  input  logic [7:0]             byte_in,
  input  logic                   frame_ready_in,
  output logic                   frame_valid_out,
  output logic                   mode_out,
  output logic [8*KEY_BYTES-1:0] key_out,
  output logic [8*MSG_BYTES-1:0] msg_out,
  output logic                   err_valid_out,
  output logic [1:0]             err_code_out,
  output logic                   overrun_out
);

  localparam int KW      = 8 * KEY_BYTES;
  localparam int MW      = 8 * MSG_BYTES;
  localparam int IDX_MAX = (KEY_BYTES > MSG_BYTES) ? KEY_BYTES : MSG_BYTES;
  localparam int IW      = $clog2(IDX_MAX + 1);
  localparam int TW      = $clog2(TIMEOUT_CYCLES);

  localparam logic [IW-1:0] KEY_LAST = IW'(KEY_BYTES - 1);
  localparam logic [IW-1:0] MSG_LAST = IW'(MSG_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_MODE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MODE,
    S_KEY,
    S_MSG,
    S_CSUM,
    S_HOLD
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_mode_sh;
  logic [KW-1:0] r_key_sh;
  logic [MW-1:0] r_msg_sh;
  logic [7:0]    r_csum;
  logic [IW-1:0] r_idx;
  logic [TW-1:0] r_tmo;

  logic          r_frame_vld;
  logic          r_mode;
  logic [KW-1:0] r_key;
  logic [MW-1:0] r_msg;
  logic          r_err_vld;
  logic [1:0]    r_err_code;
  logic          r_overrun;

  logic          w_active;
  logic          w_tmo_exp;
  logic          w_err_fire;
  logic [1:0]    w_err_code;
  logic          w_load_mode;
  logic          w_shift_key;
  logic          w_shift_msg;
  logic          w_idx_wrap;
  logic          w_commit;
  logic          w_xfer;
  logic          w_ovr_set;

  assign w_active  = (r_state == S_MODE) || (r_state == S_KEY) ||
                     (r_state == S_MSG)  || (r_state == S_CSUM);
  // A byte in the expiry cycle wins over the timeout.
  assign w_tmo_exp = w_active && !byte_valid_in && (r_tmo == TMO_LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_fire  = 1'b0;
    w_err_code  = 2'd0;
    w_load_mode = 1'b0;
    w_shift_key = 1'b0;
    w_shift_msg = 1'b0;
    w_idx_wrap  = 1'b0;
    w_commit    = 1'b0;
    w_xfer      = 1'b0;
    w_ovr_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (byte_valid_in && (byte_in == SOF_BYTE)) begin
          w_state_nxt = S_MODE;
        end
      end
      S_MODE: begin
        if (byte_valid_in) begin
          if (byte_in <= 8'd1) begin
            w_load_mode = 1'b1;
            w_state_nxt = S_KEY;
          end else begin
            w_err_fire  = 1'b1;
            w_err_code  = ERR_MODE;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_KEY: begin
        if (byte_valid_in) begin
          w_shift_key = 1'b1;
          if (r_idx == KEY_LAST) begin
            w_idx_wrap  = 1'b1;
            w_state_nxt = S_MSG;
          end
        end
      end
      S_MSG: begin
        if (byte_valid_in) begin
          w_shift_msg = 1'b1;
          if (r_idx == MSG_LAST) begin
            w_idx_wrap  = 1'b1;
            w_state_nxt = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (byte_valid_in) begin
          if (byte_in == r_csum) begin
            w_commit    = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_err_fire  = 1'b1;
            w_err_code  = ERR_CSUM;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        // Bytes here are never parsed, not even a SOF.
        w_ovr_set = byte_valid_in;
        if (r_frame_vld && frame_ready_in) begin
          w_xfer      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_tmo_exp) begin
      w_err_fire  = 1'b1;
      w_err_code  = ERR_TMO;
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_mode_sh <= 1'b0;
      r_key_sh  <= '0;
      r_msg_sh  <= '0;
      r_csum    <= 8'd0;
      r_idx     <= '0;
      r_tmo     <= '0;
    end else begin
      if (w_load_mode) begin
        r_mode_sh <= byte_in[0];
        r_csum    <= byte_in;
      end else if (w_shift_key || w_shift_msg) begin
        r_csum    <= r_csum ^ byte_in;
      end
      if (w_shift_key) begin
        r_key_sh <= (r_key_sh << 8) | KW'(byte_in);
      end
      if (w_shift_msg) begin
        r_msg_sh <= (r_msg_sh << 8) | MW'(byte_in);
      end
      if (w_load_mode || w_idx_wrap) begin
        r_idx <= '0;
      end else if (w_shift_key || w_shift_msg) begin
        r_idx <= r_idx + IW'(1);
      end
      if (w_active && !byte_valid_in && !w_tmo_exp) begin
        r_tmo <= r_tmo + TW'(1);
      end else begin
        r_tmo <= '0;
      end
    end
  end

  // Visible outputs only move on a good checksum, so errors leave the previous frame intact.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_frame_vld <= 1'b0;
      r_mode      <= 1'b0;
      r_key       <= '0;
      r_msg       <= '0;
      r_err_vld   <= 1'b0;
      r_err_code  <= 2'd0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_commit) begin
        r_frame_vld <= 1'b1;
        r_mode      <= r_mode_sh;
        r_key       <= r_key_sh;
        r_msg       <= r_msg_sh;
      end else if (w_xfer) begin
        r_frame_vld <= 1'b0;
      end
      r_err_vld <= w_err_fire;
      if (w_err_fire) begin
        r_err_code <= w_err_code;
      end
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign frame_valid_out = r_frame_vld;
  assign mode_out        = r_mode;
  assign key_out         = r_key;
  assign msg_out         = r_msg;
  assign err_valid_out   = r_err_vld;
  assign err_code_out    = r_err_code;
  assign overrun_out     = r_overrun;

endmodule

// File: doc/keychain_frame_assembler.md
Name: keychain_frame_assembler

Overview:
- Sits between the UART byte receiver and the keychain cipher core.
- Parses the incoming byte stream into framed requests: SOF, mode, KEY_BYTES key bytes, MSG_BYTES message bytes, checksum.
- Presents each validated request as wide key/message buses with a valid/ready handshake.
- Adds what the fixed-width keychain datapath lacks: parametrised field widths, an encrypt/decrypt mode, integrity checking, inter-byte timeout and overrun reporting.

Parameters:
- KEY_BYTES, 2, number of key bytes per frame (>=1).
- MSG_BYTES, 1, number of message bytes per frame (>=1).
- SOF_BYTE, 8'hA5, start-of-frame marker.
- TIMEOUT_CYCLES, 100_000, maximum idle clk_in cycles allowed between bytes inside a frame (>=2).

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- byte_valid_in  input  1  one-cycle strobe, byte_in is valid
- byte_in  input  8  received UART byte
- frame_ready_in  input  1  downstream accepts the frame
- frame_valid_out  output  1  frame available; held until accepted
- mode_out  output  1  0 = encrypt, 1 = decrypt
- key_out  output  8*KEY_BYTES  key; first received byte in the MSBs
- msg_out  output  8*MSG_BYTES  message; first received byte in the MSBs
- err_valid_out  output  1  one-cycle error strobe
- err_code_out  output  2  1 = checksum, 2 = timeout, 3 = bad mode; holds its last value
- overrun_out  output  1  sticky: a byte arrived while a frame was pending

Behaviour:
- Reset: rst_n_in low asynchronously clears all outputs, the state and all counters to 0, and returns the FSM to IDLE. Applies mid-frame too; the partial frame is discarded with no error.
- FSM states: IDLE, MODE, KEY, MSG, CSUM, HOLD.
- A "byte" below means a cycle with byte_valid_in = 1.
- IDLE:
  - byte == SOF_BYTE -> MODE.
  - Any other byte is discarded silently.
- MODE:
  - byte in {0,1} -> latch it into the shadow mode, seed the running XOR with it, -> KEY.
  - byte > 1 -> err_code 3, -> IDLE.
- KEY:
  - Shift each byte into the shadow key and XOR it into the checksum.
  - After KEY_BYTES bytes -> MSG. The byte index counter is sized with $clog2(max(KEY_BYTES, MSG_BYTES)+1).
- MSG: same as KEY, into the shadow message; after MSG_BYTES bytes -> CSUM.
- CSUM:
  - byte == running XOR -> copy the shadow registers to mode_out/key_out/msg_out, assert frame_valid_out, -> HOLD.
  - Otherwise err_code 1, -> IDLE.
- Output registers: change only on a good checksum. On any error they keep the previous frame.
- Latency: frame_valid_out rises on the clock edge after the checksum byte cycle.
- HOLD:
  - frame_valid_out stays high. Transfer occurs in a cycle where frame_valid_out && frame_ready_in.
  - On transfer, next cycle: frame_valid_out = 0, -> IDLE.
  - A byte arriving in HOLD is dropped and sets overrun_out. It is never parsed, even if it is SOF.
  - overrun_out is cleared only by reset.
- frame_ready_in is ignored whenever frame_valid_out = 0.
- Timeout:
  - Counter clears on every byte and runs in MODE/KEY/MSG/CSUM only; it is held at 0 in IDLE and HOLD.
  - Counter reaching TIMEOUT_CYCLES-1 with no byte -> err_code 2, -> IDLE.
  - If a byte and expiry coincide, the byte wins and the counter clears.
- Errors:
  - err_valid_out pulses high for exactly one cycle, the cycle after the offending byte or expiry.
  - err_code_out is updated in the same cycle as the pulse.
- Back-to-back frames: the SOF of the next frame may arrive in the cycle immediately after the transfer cycle, when the FSM is in IDLE.
- Bytes arriving every cycle must be accepted; there are no bubbles or stalls on the input side.

Test Plan:
- Defaults, frame_ready_in tied 1; send A5,00,12,34,56,checksum 00^12^34^56 = 70 -> frame_valid_out high 1 cycle after the 70 byte; mode_out = 0, key_out = 16'h1234, msg_out = 8'h56; no error.
- Same frame with checksum 71 -> err_valid_out 1 cycle, err_code_out = 1, frame_valid_out stays 0; then send a good frame 01,AB,CD,EF,checksum 01^AB^CD^EF = 88 -> mode_out = 1, key_out = 16'hABCD, msg_out = 8'hEF.
- Noise 00,FF,5A then A5,02 -> the noise produces no error; the mode byte 02 gives err_code_out = 3, FSM back in IDLE.
- TIMEOUT_CYCLES = 16; send A5,00,12 then 16 idle cycles -> err_code_out = 2 at the expiry cycle; a byte on exactly the 15th idle cycle -> no error.
- frame_ready_in = 0 after a good frame; send 3 bytes -> frame_valid_out held, outputs unchanged, overrun_out = 1; raise ready -> frame_valid_out drops the next cycle; overrun_out stays 1 until reset.
- Assert rst_n_in low after A5,00,12 -> all outputs 0 immediately, asynchronously; release and send a full good frame -> decodes correctly.
